read_ptr_empty_sync: RTL and testbench



---
 rtl/read_ptr_empty_sync.sv | 87 ++++++++
 tb/tb_read_ptr_empty_sync.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_ptr_empty_sync.sv
// Read-side controller for the async FIFO: read pointer, write-pointer synchroniser, empty and occupancy flags.
// Optional sticky underflow output is enabled with `define RD_UNDERFLOW_FLAG_EN.
module read_ptr_empty_sync #(
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 1
) (
    input  logic              rclk,
    input  logic              r_rst_n,
    input  logic              r_en,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W-1:0] raddr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
`ifdef RD_UNDERFLOW_FLAG_EN
    output logic              underflow,
`endif
    output logic              rd_ack
);

    localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AE_THRESH);

    logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
    logic [ADDR_W:0] wq_gray;
    logic [ADDR_W:0] wq_bin;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rbin_nxt;
    logic [ADDR_W:0] rgray_nxt;
    logic [ADDR_W:0] occ_nxt;
    logic            rd_fire;

    // Only sync_q[0] may sample the asynchronous write pointer.
    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_bin = '0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            wq_bin[i] = ^(wq_gray >> i);
        end
    end

    assign rd_fire   = r_en & ~empty;
    assign rbin_nxt  = rbin + {{ADDR_W{1'b0}}, rd_fire};
    assign rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
    assign occ_nxt   = wq_bin - rbin_nxt;
    assign raddr     = rbin[ADDR_W-1:0];

    // Flags are computed from the post-read pointer so the last read raises empty on its own edge.
    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            rd_count     <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_ack       <= 1'b0;
        end else begin
            rbin         <= rbin_nxt;
            rptr_gray    <= rgray_nxt;
            rd_count     <= occ_nxt;
            empty        <= (rgray_nxt == wq_gray);
            almost_empty <= (occ_nxt <= AE_LIM);
            rd_ack       <= rd_fire;
        end
    end

`ifdef RD_UNDERFLOW_FLAG_EN
    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            underflow <= 1'b0;
        end else if (r_en && empty) begin
            underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_read_ptr_empty_sync.sv
// Randomised self-checking bench for read_ptr_empty_sync against a count-based FIFO model.
// Honours `define RD_UNDERFLOW_FLAG_EN when the design is built with it.
module tb_read_ptr_empty_sync;

    localparam int ADDR_W = 2;
    localparam int SYNC   = 2;
    localparam int AE     = 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MOD    = 2 * DEPTH;

    logic              rclk;
    logic              r_rst_n;
    logic              r_en;
    logic [ADDR_W:0]   wptr_gray;
    logic [ADDR_W:0]   rptr_gray;
    logic [ADDR_W-1:0] raddr;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              rd_ack;
`ifdef RD_UNDERFLOW_FLAG_EN
    logic              underflow;
`endif

    read_ptr_empty_sync #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC),
        .AE_THRESH   (AE)
    ) dut (
        .rclk         (rclk),
        .r_rst_n      (r_rst_n),
        .r_en         (r_en),
        .wptr_gray    (wptr_gray),
        .rptr_gray    (rptr_gray),
        .raddr        (raddr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
`ifdef RD_UNDERFLOW_FLAG_EN
        .underflow    (underflow),
`endif
        .rd_ack       (rd_ack)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: total writes issued, total reads accepted, and write counts seen by the sync chain.
    int wcnt = 0;
    int rcnt = 0;
    int hist[$];
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_ack   = 1'b0;
    bit m_uf    = 1'b0;
    int m_count = 0;

    function automatic logic [ADDR_W:0] to_gray(input int v);
        logic [ADDR_W:0] b;
        b = (ADDR_W+1)'(v % MOD);
        return b ^ (b >> 1);
    endfunction

    task automatic tick(input bit rst_n_v, input bit ren_v);
        int wq;
        bit fire;
        r_rst_n   = rst_n_v;
        r_en      = ren_v;
        wptr_gray = to_gray(wcnt);
        @(posedge rclk);
        if (!rst_n_v) begin
            rcnt = 0;
            hist.delete();
            repeat (SYNC) hist.push_back(0);
            m_empty = 1'b1; m_ae = 1'b1; m_ack = 1'b0; m_count = 0; m_uf = 1'b0;
        end else begin
            wq = hist.pop_front();
            hist.push_back(wcnt % MOD);
            fire = ren_v && !m_empty;
            if (ren_v && m_empty) m_uf = 1'b1;
            if (fire) rcnt++;
            m_count = ((wq - rcnt) % MOD + MOD) % MOD;
            m_empty = (m_count == 0);
            m_ae    = (m_count <= AE);
            m_ack   = fire;
        end
        #1;
    endtask

    task automatic test_reset();
        wcnt = 2;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tests_run++;
        if (empty !== 1'b1 || almost_empty !== 1'b1 || rd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: empty=%b ae=%b ack=%b, required 1 1 0", empty, almost_empty, rd_ack);
        end
        tests_run++;
        if (rptr_gray !== 3'b000 || raddr !== 2'd0 || rd_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_ptrs: rptr=%b raddr=%0d count=%0d, required 000 0 0", rptr_gray, raddr, rd_count);
        end
`ifdef RD_UNDERFLOW_FLAG_EN
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_underflow: got %b, required 0", underflow);
        end
`endif
    endtask

    task automatic test_single_write();
        wcnt = 0;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        wcnt = 1;
        for (int e = 1; e <= 3; e++) begin
            tick(1'b1, 1'b0);
            tests_run++;
            if (empty !== (e < 3) || rd_count !== ((e < 3) ? 3'd0 : 3'd1) || almost_empty !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_write_e%0d: empty=%b count=%0d ae=%b, required %b %0d 1",
                         e, empty, rd_count, almost_empty, (e < 3), (e < 3) ? 0 : 1);
            end
        end
    endtask

    task automatic test_drain();
        int acks;
        logic [ADDR_W-1:0] exp_addr;
        wcnt = 4;
        repeat (3) tick(1'b1, 1'b0);
        tests_run++;
        if (rd_count !== 3'd4 || empty !== 1'b0 || almost_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_full: count=%0d empty=%b ae=%b, required 4 0 0", rd_count, empty, almost_empty);
        end
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            exp_addr = ADDR_W'(k < 4 ? k : 0);
            tests_run++;
            if (raddr !== exp_addr) begin
                tests_failed++;
                $display("FAIL drain_raddr_%0d: got %0d, required %0d", k, raddr, exp_addr);
            end
            tick(1'b1, k < 5);
            if (rd_ack === 1'b1) acks++;
            tests_run++;
            if (rptr_gray !== to_gray(rcnt) || rd_count !== 3'(m_count) || empty !== m_empty ||
                almost_empty !== m_ae || rd_ack !== m_ack) begin
                tests_failed++;
                $display("FAIL drain_step_%0d: rptr=%b cnt=%0d e=%b ae=%b ack=%b, required %b %0d %b %b %b",
                         k, rptr_gray, rd_count, empty, almost_empty, rd_ack,
                         to_gray(rcnt), m_count, m_empty, m_ae, m_ack);
            end
        end
        tests_run++;
        if (acks != 4) begin
            tests_failed++;
            $display("FAIL drain_ack_count: got %0d, required 4", acks);
        end
    endtask

    task automatic test_wrap();
        wcnt = 8;
        repeat (3) tick(1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tests_run++;
        if (rptr_gray !== 3'b000 || raddr !== 2'd0 || empty !== 1'b1 || rd_count !== 3'd0 || rcnt != 8) begin
            tests_failed++;
            $display("FAIL wrap: rptr=%b raddr=%0d empty=%b count=%0d reads=%0d, required 000 0 1 0 8",
                     rptr_gray, raddr, empty, rd_count, rcnt);
        end
    endtask

    task automatic test_underflow();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            tests_run++;
            if (rptr_gray !== 3'b000 || raddr !== 2'd0 || rd_ack !== 1'b0 || rd_count !== 3'd0) begin
                tests_failed++;
                $display("FAIL underflow_frozen_%0d: rptr=%b raddr=%0d ack=%b count=%0d, required 000 0 0 0",
                         k, rptr_gray, raddr, rd_ack, rd_count);
            end
        end
        repeat (2) tick(1'b1, 1'b0);
`ifdef RD_UNDERFLOW_FLAG_EN
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow_sticky: got %b, required 1", underflow);
        end
`endif
    endtask

    task automatic test_mid_reset();
        wcnt = 11;
        repeat (3) tick(1'b1, 1'b0);
        tests_run++;
        if (rd_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL midrst_pre: count=%0d, required 3", rd_count);
        end
        tick(1'b0, 1'b1);
        tests_run++;
        if (rd_count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || rptr_gray !== 3'b000 || rd_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_reset: count=%0d e=%b ae=%b rptr=%b ack=%b, required 0 1 1 000 0",
                     rd_count, empty, almost_empty, rptr_gray, rd_ack);
        end
`ifdef RD_UNDERFLOW_FLAG_EN
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_underflow: got %b, required 0", underflow);
        end
`endif
        for (int e = 1; e <= 3; e++) begin
            tick(1'b1, 1'b0);
            tests_run++;
            if (empty !== (e < 3) || rd_count !== ((e < 3) ? 3'd0 : 3'd3)) begin
                tests_failed++;
                $display("FAIL midrst_release_e%0d: empty=%b count=%0d, required %b %0d",
                         e, empty, rd_count, (e < 3), (e < 3) ? 0 : 3);
            end
        end
    endtask

    task automatic test_random();
        wcnt = wcnt % MOD;
        for (int k = 0; k < 400; k++) begin
            if ((wcnt - rcnt) < DEPTH && $urandom_range(0, 1) == 1) wcnt++;
            tick(1'b1, $urandom_range(0, 2) != 0);
            tests_run++;
            if (rptr_gray !== to_gray(rcnt) || raddr !== ADDR_W'(rcnt % DEPTH) ||
                rd_count !== 3'(m_count) || empty !== m_empty || almost_empty !== m_ae ||
                rd_ack !== m_ack) begin
                tests_failed++;
                $display("FAIL random_%0d: rptr=%b raddr=%0d cnt=%0d e=%b ae=%b ack=%b, required %b %0d %0d %b %b %b",
                         k, rptr_gray, raddr, rd_count, empty, almost_empty, rd_ack,
                         to_gray(rcnt), rcnt % DEPTH, m_count, m_empty, m_ae, m_ack);
            end
            tests_run++;
            if (rd_count > 3'(DEPTH)) begin
                tests_failed++;
                $display("FAIL random_bound_%0d: count=%0d, required <= %0d", k, rd_count, DEPTH);
            end
`ifdef RD_UNDERFLOW_FLAG_EN
            tests_run++;
            if (underflow !== m_uf) begin
                tests_failed++;
                $display("FAIL random_underflow_%0d: got %b, required %b", k, underflow, m_uf);
            end
`endif
        end
    endtask

    initial begin
        r_rst_n   = 1'b0;
        r_en      = 1'b0;
        wptr_gray = '0;
        #2;
        test_reset();
        test_single_write();
        test_drain();
        test_wrap();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
